// File: rtl/rv32_core_pkg.sv
// Shared definitions for the single-cycle RV32I core.
// Holds the opcode/funct3/funct7 encodings, the ALU operation and decoded
// instruction enums, and the internal selector enums used by the top.
package rv32_core_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_WORD = 3'b010;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } aluop_e;

  typedef enum logic [5:0] {
    CU_ILLEGAL = 6'd0,
    CU_ADD, CU_SUB, CU_AND, CU_OR, CU_XOR, CU_SLL, CU_SRL, CU_SRA, CU_SLT, CU_SLTU,
    CU_ADDI, CU_ANDI, CU_ORI, CU_XORI, CU_SLTI, CU_SLTIU, CU_SLLI, CU_SRLI, CU_SRAI,
    CU_LW, CU_SW,
    CU_BEQ, CU_BNE, CU_BLT, CU_BGE,
    CU_LUI, CU_JAL
  } cuop_e;

  typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_J, IMM_U} imm_fmt_e;

  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4, WB_IMM} wb_sel_e;

endpackage

// File: rtl/rv32_regfile.sv
// 32 x 32-bit integer register file.
// Ports: clk/nrst (async active-low reset clears all registers), we/waddr/wdata
// single write port, raddr1/raddr2 -> rdata1/rdata2 combinational read ports.
// x0 is not stored: it always reads zero and writes to it are dropped.
module rv32_regfile (
  input  logic        clk,
  input  logic        nrst,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2
);

  logic [31:0] regs [1:31];

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 1; i < 32; i++) regs[i] <= '0;
    end else if (we && waddr != 5'd0) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == 5'd0) ? 32'd0 : regs[raddr1];
  assign rdata2 = (raddr2 == 5'd0) ? 32'd0 : regs[raddr2];

endmodule

// File: rtl/rv32_single_cycle_core.sv
// Single-cycle RV32I core with external instruction input and internal data
// memory. Inputs: clk, nrst (async active-low), instruction. Outputs: pc plus
// every internal datapath signal (decode IDs, register indices, immediates,
// register read data, ALU operand/result/flags, memory read data, writeback).
module rv32_single_cycle_core
  import rv32_core_pkg::*;
#(
  parameter int          DMEM_WORDS = 256,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [31:0] instruction,
  output logic [31:0] pc,
  output logic [5:0]  cuOP,
  output logic [3:0]  aluOP,
  output logic        aluSrc,
  output logic [4:0]  regsel1,
  output logic [4:0]  regsel2,
  output logic [4:0]  w_reg,
  output logic [19:0] imm,
  output logic [31:0] immOut,
  output logic [31:0] regData1,
  output logic [31:0] regData2,
  output logic [31:0] aluIn,
  output logic [31:0] aluOut,
  output logic        zero,
  output logic        negative,
  output logic [31:0] memload,
  output logic [31:0] writeData
);

  localparam int AW = $clog2(DMEM_WORDS);

  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  cuop_e       cu;
  aluop_e      alu_op;
  imm_fmt_e    imm_fmt;
  wb_sel_e     wb_sel;
  logic        reg_we, mem_we, take_branch;
  logic [31:0] pc_plus4, next_pc;
  logic [31:0] dmem [DMEM_WORDS];
  logic [AW-1:0] dmem_addr;

  assign opcode  = instruction[6:0];
  assign funct3  = instruction[14:12];
  assign funct7  = instruction[31:25];
  assign regsel1 = instruction[19:15];
  assign regsel2 = instruction[24:20];
  assign w_reg   = instruction[11:7];
  assign imm     = instruction[31:12];

  // Instruction decode; anything not matched exactly stays ILLEGAL.
  always_comb begin
    cu = CU_ILLEGAL;
    case (opcode)
      OP_R: begin
        case ({funct7, funct3})
          {F7_BASE, F3_ADD}:  cu = CU_ADD;
          {F7_ALT,  F3_ADD}:  cu = CU_SUB;
          {F7_BASE, F3_AND}:  cu = CU_AND;
          {F7_BASE, F3_OR}:   cu = CU_OR;
          {F7_BASE, F3_XOR}:  cu = CU_XOR;
          {F7_BASE, F3_SLL}:  cu = CU_SLL;
          {F7_BASE, F3_SR}:   cu = CU_SRL;
          {F7_ALT,  F3_SR}:   cu = CU_SRA;
          {F7_BASE, F3_SLT}:  cu = CU_SLT;
          {F7_BASE, F3_SLTU}: cu = CU_SLTU;
          default:            cu = CU_ILLEGAL;
        endcase
      end
      OP_I: begin
        case (funct3)
          F3_ADD:  cu = CU_ADDI;
          F3_AND:  cu = CU_ANDI;
          F3_OR:   cu = CU_ORI;
          F3_XOR:  cu = CU_XORI;
          F3_SLT:  cu = CU_SLTI;
          F3_SLTU: cu = CU_SLTIU;
          F3_SLL:  if (funct7 == F7_BASE) cu = CU_SLLI;
          F3_SR: begin
            if (funct7 == F7_BASE)     cu = CU_SRLI;
            else if (funct7 == F7_ALT) cu = CU_SRAI;
          end
          default: cu = CU_ILLEGAL;
        endcase
      end
      OP_LOAD:  if (funct3 == F3_WORD) cu = CU_LW;
      OP_STORE: if (funct3 == F3_WORD) cu = CU_SW;
      OP_BRANCH: begin
        case (funct3)
          F3_BEQ:  cu = CU_BEQ;
          F3_BNE:  cu = CU_BNE;
          F3_BLT:  cu = CU_BLT;
          F3_BGE:  cu = CU_BGE;
          default: cu = CU_ILLEGAL;
        endcase
      end
      OP_LUI:  cu = CU_LUI;
      OP_JAL:  cu = CU_JAL;
      default: cu = CU_ILLEGAL;
    endcase
  end

  // Control signals derived from the decoded instruction.
  always_comb begin
    alu_op  = ALU_ADD;
    aluSrc  = 1'b0;
    imm_fmt = IMM_NONE;
    wb_sel  = WB_ALU;
    reg_we  = 1'b0;
    mem_we  = 1'b0;
    case (cu)
      CU_ADD:   begin alu_op = ALU_ADD;  reg_we = 1'b1; end
      CU_SUB:   begin alu_op = ALU_SUB;  reg_we = 1'b1; end
      CU_AND:   begin alu_op = ALU_AND;  reg_we = 1'b1; end
      CU_OR:    begin alu_op = ALU_OR;   reg_we = 1'b1; end
      CU_XOR:   begin alu_op = ALU_XOR;  reg_we = 1'b1; end
      CU_SLL:   begin alu_op = ALU_SLL;  reg_we = 1'b1; end
      CU_SRL:   begin alu_op = ALU_SRL;  reg_we = 1'b1; end
      CU_SRA:   begin alu_op = ALU_SRA;  reg_we = 1'b1; end
      CU_SLT:   begin alu_op = ALU_SLT;  reg_we = 1'b1; end
      CU_SLTU:  begin alu_op = ALU_SLTU; reg_we = 1'b1; end
      CU_ADDI:  begin alu_op = ALU_ADD;  reg_we = 1'b1; aluSrc = 1'b1; imm_fmt = IMM_I; end
      CU_ANDI:  begin alu_op = ALU_AND;  reg_we = 1'b1; aluSrc = 1'b1; imm_fmt = IMM_I; end
      CU_ORI:   begin alu_op = ALU_OR;   reg_we = 1'b1; aluSrc = 1'b1; imm_fmt = IMM_I; end
      CU_XORI:  begin alu_op = ALU_XOR;  reg_we = 1'b1; aluSrc = 1'b1; imm_fmt = IMM_I; end
      CU_SLTI:  begin alu_op = ALU_SLT;  reg_we = 1'b1; aluSrc = 1'b1; imm_fmt = IMM_I; end
      CU_SLTIU: begin alu_op = ALU_SLTU; reg_we = 1'b1; aluSrc = 1'b1; imm_fmt = IMM_I; end
      CU_SLLI:  begin alu_op = ALU_SLL;  reg_we = 1'b1; aluSrc = 1'b1; imm_fmt = IMM_I; end
      CU_SRLI:  begin alu_op = ALU_SRL;  reg_we = 1'b1; aluSrc = 1'b1; imm_fmt = IMM_I; end
      CU_SRAI:  begin alu_op = ALU_SRA;  reg_we = 1'b1; aluSrc = 1'b1; imm_fmt = IMM_I; end
      CU_LW:    begin reg_we = 1'b1; aluSrc = 1'b1; imm_fmt = IMM_I; wb_sel = WB_MEM; end
      CU_SW:    begin mem_we = 1'b1; aluSrc = 1'b1; imm_fmt = IMM_S; end
      CU_BEQ, CU_BNE: begin alu_op = ALU_SUB; imm_fmt = IMM_B; end
      CU_BLT, CU_BGE: begin alu_op = ALU_SLT; imm_fmt = IMM_B; end
      CU_LUI:   begin reg_we = 1'b1; imm_fmt = IMM_U; wb_sel = WB_IMM; end
      CU_JAL:   begin reg_we = 1'b1; imm_fmt = IMM_J; wb_sel = WB_PC4; end
      default:  ;
    endcase
  end

  always_comb begin
    immOut = 32'd0;
    case (imm_fmt)
      IMM_I: immOut = {{20{instruction[31]}}, instruction[31:20]};
      IMM_S: immOut = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
      IMM_B: immOut = {{19{instruction[31]}}, instruction[31], instruction[7],
                       instruction[30:25], instruction[11:8], 1'b0};
      IMM_J: immOut = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                       instruction[20], instruction[30:21], 1'b0};
      IMM_U: immOut = {instruction[31:12], 12'd0};
      default: immOut = 32'd0;
    endcase
  end

  rv32_regfile u_regfile (
    .clk    (clk),
    .nrst   (nrst),
    .we     (reg_we),
    .waddr  (w_reg),
    .wdata  (writeData),
    .raddr1 (regsel1),
    .raddr2 (regsel2),
    .rdata1 (regData1),
    .rdata2 (regData2)
  );

  assign aluIn = aluSrc ? immOut : regData2;

  always_comb begin
    aluOut = 32'd0;
    case (alu_op)
      ALU_ADD:  aluOut = regData1 + aluIn;
      ALU_SUB:  aluOut = regData1 - aluIn;
      ALU_AND:  aluOut = regData1 & aluIn;
      ALU_OR:   aluOut = regData1 | aluIn;
      ALU_XOR:  aluOut = regData1 ^ aluIn;
      ALU_SLL:  aluOut = regData1 << aluIn[4:0];
      ALU_SRL:  aluOut = regData1 >> aluIn[4:0];
      ALU_SRA:  aluOut = $unsigned($signed(regData1) >>> aluIn[4:0]);
      ALU_SLT:  aluOut = {31'd0, $signed(regData1) < $signed(aluIn)};
      ALU_SLTU: aluOut = {31'd0, regData1 < aluIn};
      default:  aluOut = 32'd0;
    endcase
  end

  assign zero     = (aluOut == 32'd0);
  assign negative = aluOut[31];

  // Word-addressed data memory; the byte offset bits of the address are dropped.
  assign dmem_addr = aluOut[AW+1:2];
  assign memload   = dmem[dmem_addr];

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < DMEM_WORDS; i++) dmem[i] <= '0;
    end else if (mem_we) begin
      dmem[dmem_addr] <= regData2;
    end
  end

  assign pc_plus4 = pc + 32'd4;

  always_comb begin
    case (wb_sel)
      WB_MEM:  writeData = memload;
      WB_PC4:  writeData = pc_plus4;
      WB_IMM:  writeData = immOut;
      default: writeData = aluOut;
    endcase
  end

  // Branch conditions reuse the ALU: SUB gives equality via zero, SLT gives
  // the signed less-than result in bit 0.
  always_comb begin
    take_branch = 1'b0;
    case (cu)
      CU_BEQ:  take_branch = zero;
      CU_BNE:  take_branch = !zero;
      CU_BLT:  take_branch = aluOut[0];
      CU_BGE:  take_branch = !aluOut[0];
      CU_JAL:  take_branch = 1'b1;
      default: take_branch = 1'b0;
    endcase
    next_pc = take_branch ? (pc + immOut) : pc_plus4;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) pc <= RESET_PC;
    else       pc <= next_pc;
  end

  assign cuOP  = cu;
  assign aluOP = alu_op;

endmodule

// File: tb/tb_rv32_single_cycle_core.sv
// Self-checking bench for rv32_single_cycle_core. Each driven instruction
// pushes its expected pc/aluOut/writeData onto a scoreboard queue that a
// monitor pops and compares mid-cycle; scenario tasks add inline checks.
module tb_rv32_single_cycle_core;
  import rv32_core_pkg::*;

  logic        clk;
  logic        nrst;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic [5:0]  cuOP;
  logic [3:0]  aluOP;
  logic        aluSrc;
  logic [4:0]  regsel1, regsel2, w_reg;
  logic [19:0] imm;
  logic [31:0] immOut, regData1, regData2, aluIn, aluOut;
  logic        zero, negative;
  logic [31:0] memload, writeData;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic [31:0] alu;
    logic        alu_care;
    logic [31:0] wd;
    logic        wd_care;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] exp_pc;
  int          checks;
  int          errors;

  rv32_single_cycle_core #(
    .DMEM_WORDS (256),
    .RESET_PC   (32'h0000_0000)
  ) dut (
    .clk         (clk),
    .nrst        (nrst),
    .instruction (instruction),
    .pc          (pc),
    .cuOP        (cuOP),
    .aluOP       (aluOP),
    .aluSrc      (aluSrc),
    .regsel1     (regsel1),
    .regsel2     (regsel2),
    .w_reg       (w_reg),
    .imm         (imm),
    .immOut      (immOut),
    .regData1    (regData1),
    .regData2    (regData2),
    .aluIn       (aluIn),
    .aluOut      (aluOut),
    .zero        (zero),
    .negative    (negative),
    .memload     (memload),
    .writeData   (writeData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard monitor: three time units after each falling edge, well clear
  // of the rising edge, compare whatever was queued for this cycle.
  always begin
    @(negedge clk);
    #3;
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (pc !== e.pc) begin
        errors++;
        $display("[TB] FAIL %s pc: got %h expected %h", e.tag, pc, e.pc);
      end
      if (e.alu_care) begin
        checks++;
        if (aluOut !== e.alu) begin
          errors++;
          $display("[TB] FAIL %s aluOut: got %h expected %h", e.tag, aluOut, e.alu);
        end
      end
      if (e.wd_care) begin
        checks++;
        if (writeData !== e.wd) begin
          errors++;
          $display("[TB] FAIL %s writeData: got %h expected %h", e.tag, writeData, e.wd);
        end
      end
    end
  end

  // Drive one instruction at the falling edge and queue its expectations;
  // pc_off is how far pc must move after this instruction executes.
  task automatic drive(input string tag, input logic [31:0] instr,
                       input logic [31:0] alu, input logic alu_care,
                       input logic [31:0] wd, input logic wd_care,
                       input logic [31:0] pc_off);
    exp_t e;
    @(negedge clk);
    instruction = instr;
    e.tag = tag;
    e.pc = exp_pc;
    e.alu = alu;
    e.alu_care = alu_care;
    e.wd = wd;
    e.wd_care = wd_care;
    sb.push_back(e);
    exp_pc = exp_pc + pc_off;
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    instruction = 32'h0000_0000;
    repeat (2) @(negedge clk);
    #2;
    checks++;
    if (pc !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_pc: got %h expected %h", pc, 32'h0);
    end
    checks++;
    if (cuOP !== 6'(CU_ILLEGAL)) begin
      errors++;
      $display("[TB] FAIL reset_cuop: got %0d expected %0d", cuOP, 0);
    end
  endtask

  task automatic test_alu_imm();
    exp_pc = 32'h0;
    drive("addi_x1", 32'h3e800093, 32'h3E8, 1'b1, 32'h3E8, 1'b1, 32'd4);
    #1 nrst = 1'b1;
    #1;
    checks++;
    if (aluSrc !== 1'b1 || immOut !== 32'h3E8 || w_reg !== 5'd1 || cuOP !== 6'(CU_ADDI)) begin
      errors++;
      $display("[TB] FAIL addi_decode: got aluSrc=%b immOut=%h w_reg=%0d cuOP=%0d expected 1 3e8 1 %0d",
               aluSrc, immOut, w_reg, cuOP, 6'(CU_ADDI));
    end
    drive("addi_x2_neg", 32'h83000113, 32'hFFFFF830, 1'b1, 32'hFFFFF830, 1'b1, 32'd4);
    #2;
    checks++;
    if (immOut !== 32'hFFFFF830 || negative !== 1'b1 || zero !== 1'b0) begin
      errors++;
      $display("[TB] FAIL addi_neg_flags: got immOut=%h neg=%b zero=%b expected fffff830 1 0",
               immOut, negative, zero);
    end
    drive("ori_x3", 32'h3e906193, 32'h3E9, 1'b1, 32'h3E9, 1'b1, 32'd4);
    drive("andi_x4_zero", 32'h45707213, 32'h0, 1'b1, 32'h0, 1'b1, 32'd4);
    #2;
    checks++;
    if (zero !== 1'b1) begin
      errors++;
      $display("[TB] FAIL andi_zero_flag: got %b expected 1", zero);
    end
    drive("andi_x4_x3", 32'h3f31f213, 32'h3E1, 1'b1, 32'h3E1, 1'b1, 32'd4);
    #2;
    checks++;
    if (regData1 !== 32'h3E9) begin
      errors++;
      $display("[TB] FAIL back_to_back_rs1: got %h expected %h", regData1, 32'h3E9);
    end
  endtask

  task automatic test_load_store();
    drive("sw_x1", 32'h00102023, 32'h0, 1'b1, 32'h0, 1'b0, 32'd4);
    #2;
    checks++;
    if (regData2 !== 32'h3E8 || aluSrc !== 1'b1) begin
      errors++;
      $display("[TB] FAIL sw_operands: got rs2=%h aluSrc=%b expected 3e8 1", regData2, aluSrc);
    end
    drive("lw_x5", 32'h00002283, 32'h0, 1'b1, 32'h3E8, 1'b1, 32'd4);
    #2;
    checks++;
    if (memload !== 32'h3E8) begin
      errors++;
      $display("[TB] FAIL lw_memload: got %h expected %h", memload, 32'h3E8);
    end
  endtask

  task automatic test_alu_reg();
    drive("add_x6",   32'h00208333, 32'hFFFFFC18, 1'b1, 32'hFFFFFC18, 1'b1, 32'd4);
    drive("sub_x7",   32'h402083B3, 32'h00000BB8, 1'b1, 32'h00000BB8, 1'b1, 32'd4);
    drive("slt_x8",   32'h00112433, 32'h1, 1'b1, 32'h1, 1'b1, 32'd4);
    drive("sltu_x9",  32'h001134B3, 32'h0, 1'b1, 32'h0, 1'b1, 32'd4);
    drive("srai_x10", 32'h40415513, 32'hFFFFFF83, 1'b1, 32'hFFFFFF83, 1'b1, 32'd4);
  endtask

  task automatic test_x0();
    drive("addi_x0", 32'h00500013, 32'h5, 1'b1, 32'h5, 1'b1, 32'd4);
    drive("add_x11_x0", 32'h001005B3, 32'h3E8, 1'b1, 32'h3E8, 1'b1, 32'd4);
    #2;
    checks++;
    if (regData1 !== 32'h0) begin
      errors++;
      $display("[TB] FAIL x0_reads_zero: got %h expected %h", regData1, 32'h0);
    end
    drive("lui_x12", 32'h12345637, 32'h0, 1'b0, 32'h12345000, 1'b1, 32'd4);
  endtask

  task automatic test_branches();
    drive("beq_taken",    32'h00000463, 32'h0, 1'b1, 32'h0, 1'b0, 32'd8);
    #2;
    checks++;
    if (immOut !== 32'h8 || zero !== 1'b1) begin
      errors++;
      $display("[TB] FAIL beq_imm: got immOut=%h zero=%b expected 8 1", immOut, zero);
    end
    drive("bne_not_taken", 32'h00001463, 32'h0, 1'b1, 32'h0, 1'b0, 32'd4);
    drive("blt_taken",     32'h00114863, 32'h1, 1'b1, 32'h0, 1'b0, 32'd16);
    drive("bge_not_taken", 32'h00115863, 32'h1, 1'b1, 32'h0, 1'b0, 32'd4);
  endtask

  task automatic test_jal_illegal();
    drive("jal_x13", 32'h00C006EF, 32'h0, 1'b0, 32'd96, 1'b1, 32'd12);
    drive("illegal", 32'hFFFFFFFF, 32'h0, 1'b0, 32'h0, 1'b0, 32'd4);
    #2;
    checks++;
    if (cuOP !== 6'(CU_ILLEGAL)) begin
      errors++;
      $display("[TB] FAIL illegal_decode: got %0d expected 0", cuOP);
    end
    drive("add_x14_x31", 32'h000F8733, 32'h0, 1'b1, 32'h0, 1'b1, 32'd4);
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    instruction = 32'h000087B3;
    #1;
    checks++;
    if (regData1 !== 32'h3E8) begin
      errors++;
      $display("[TB] FAIL pre_reset_x1: got %h expected %h", regData1, 32'h3E8);
    end
    nrst = 1'b0;
    #1;
    checks++;
    if (pc !== 32'h0 || regData1 !== 32'h0) begin
      errors++;
      $display("[TB] FAIL mid_reset: got pc=%h x1=%h expected 0 0", pc, regData1);
    end
    exp_pc = 32'h0;
    drive("lw_after_reset", 32'h00002283, 32'h0, 1'b1, 32'h0, 1'b1, 32'd4);
    #1 nrst = 1'b1;
    #1;
    checks++;
    if (memload !== 32'h0) begin
      errors++;
      $display("[TB] FAIL dmem_cleared: got %h expected %h", memload, 32'h0);
    end
    drive("addi_after_reset", 32'h3e800093, 32'h3E8, 1'b1, 32'h3E8, 1'b1, 32'd4);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    exp_pc = 32'h0;
    test_reset();
    test_alu_imm();
    test_load_store();
    test_alu_reg();
    test_x0();
    test_branches();
    test_jal_illegal();
    test_mid_reset();
    @(negedge clk);
    #4;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv32_single_cycle_core.md
Name: rv32_single_cycle_core

Overview:
- Single-cycle RV32I integer core datapath with an external instruction input and an internal data memory.
- Each clock cycle it decodes `instruction`, reads the register file, computes in the ALU, accesses data memory, writes back, and advances `pc`.
- Every internal datapath signal is brought out as an output for observation by the bench.
- It is the top of the single-cycle design. Instruction fetch is external: the bench supplies `instruction` directly.

Parameters:
- DMEM_WORDS, 256, number of 32-bit words in the internal data memory (word-addressed by aluOut[9:2]).
- RESET_PC, 32'h0000_0000, value of `pc` after reset.

Ports:
- clk  in  1  rising-edge clock
- nrst  in  1  asynchronous active-low reset
- instruction  in  32  RV32 instruction executed this cycle
- pc  out  32  current program counter
- cuOP  out  6  decoded instruction ID (package enum)
- aluOP  out  4  ALU operation (package enum)
- aluSrc  out  1  1 = ALU operand B is the immediate, 0 = operand B is rs2 data
- regsel1  out  5  rs1 index, instruction[19:15]
- regsel2  out  5  rs2 index, instruction[24:20]
- w_reg  out  5  rd index, instruction[11:7]
- imm  out  20  raw field instruction[31:12]
- immOut  out  32  sign-extended immediate for the decoded format
- regData1  out  32  register file read data for rs1
- regData2  out  32  register file read data for rs2
- aluIn  out  32  ALU operand B (after the aluSrc mux)
- aluOut  out  32  ALU result
- zero  out  1  aluOut == 0
- negative  out  1  aluOut[31]
- memload  out  32  data memory read word at aluOut
- writeData  out  32  value presented to the rd write port

Behaviour:
- Supported instructions:
  - R-type: ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU.
  - I-type ALU: ADDI, ANDI, ORI, XORI, SLTI, SLTIU, SLLI, SRLI, SRAI.
  - Memory: LW, SW.
  - Branches: BEQ, BNE, BLT, BGE.
  - Other: LUI, JAL.
- Any other encoding decodes as cuOP = ILLEGAL (0): no register or memory write, pc += 4.
- All decode, immediate, ALU, memory-read and writeData paths are combinational from `instruction` and the current state.
- State updates on the rising edge of clk only: register file, data memory, pc.
- Immediate formats, all sign-extended from instruction[31]:
  - I: [31:20]
  - S: {[31:25],[11:7]}
  - B: {[31],[7],[30:25],[11:8],0}
  - J: {[31],[19:12],[20],[30:21],0}
  - U: {[31:12],12'b0}
- aluSrc = 1 for I-type ALU, LW and SW; 0 otherwise.
- ALU arithmetic:
  - Arithmetic wraps modulo 2^32.
  - Shifts use operand B [4:0].
  - SLT is signed; SLTU is unsigned.
  - Branches use SUB (BEQ/BNE) or SLT (BLT/BGE).
- writeData source by instruction class:
  - ALU result for ALU instructions
  - memload for LW
  - pc+4 for JAL
  - immOut for LUI
- Register file:
  - 32x32 with two combinational read ports and one write port.
  - x0 always reads 0 and writes to it are ignored.
  - A write in cycle N is visible on the read ports after that rising edge.
- Data memory: SW writes regData2 to word aluOut[9:2] at the rising edge; LW reads combinationally. Address bits [1:0] are ignored.
- Next pc:
  - BEQ: pc+immOut if zero
  - BNE: pc+immOut if !zero
  - BLT: pc+immOut if aluOut[0]
  - BGE: pc+immOut if !aluOut[0]
  - JAL: pc+immOut
  - Otherwise: pc+4
- Reset (nrst low, asynchronous):
  - pc = RESET_PC.
  - All registers = 0.
  - All data memory words = 0.
  - No writes occur while nrst is low.
  - Combinational outputs track `instruction` and the reset state.
- Reset asserted mid-run clears state immediately. The first rising edge after deassertion executes the current instruction.

Decomposition:
- Package rv32_core_pkg holds:
  - opcode/funct3/funct7 constants
  - aluop_e (4-bit): ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6, SRA=7, SLT=8, SLTU=9
  - cuop_e (6-bit): ILLEGAL=0, then one value per supported instruction, in the order listed above
- One natural sub-module: rv32_regfile (32x32, async reset, x0 hardwired). ALU, decode and immediate generation stay in the top.

Test Plan:
- Reset, then 32'h3e800093 (ADDI x1,x0,1000) -> aluSrc=1, immOut=0x3E8, aluOut=0x3E8, w_reg=1, writeData=0x3E8; pc advances by 4 each cycle from 0.
- 32'h83000113 (ADDI x2,x0,-2000) -> immOut=0xFFFFF830, aluOut=0xFFFFF830, negative=1, zero=0.
- 32'h3e906193 (ORI x3,x0,1001) -> aluOut=0x3E9.
- 32'h45707213 (ANDI x4,x0,1111) -> aluOut=0, zero=1.
- Then 32'h3f31f213 (ANDI x4,x3,1011) -> regData1=0x3E9, aluOut=0x3E1.
- SW x1,0(x0) then LW x5,0(x0) -> memload=0x3E8, writeData=0x3E8.
- Write to x0 -> regData1 for rs1=x0 reads 0.
- BEQ x0,x0,+8 -> pc+8.
- Assert nrst mid-run -> pc=0 and x1 reads 0 immediately.
